// File: rtl/mem_pkg.sv
// Shared types and constants for the two-read, one-write data memory.
package mem_pkg;

    // Controller states: CLEAR zeroes the array after reset, READY serves accesses
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

    localparam int DEFAULT_WORD_SIZE   = 10;
    localparam int DEFAULT_ADDR_SIZE   = 9;
    localparam int DEFAULT_MEMORY_SIZE = 512;

    // Width of the clear counter: enough bits to address every word, never zero
    function automatic int clear_cnt_width(input int memory_size);
        int w;
        w = $clog2(memory_size);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_read_port.sv
// One registered read port: write-first bypass, out-of-range zeroing and valid flag.
module mem_read_port
    import mem_pkg::*;
#(
    parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
    parameter int ADDR_SIZE   = DEFAULT_ADDR_SIZE,
    parameter int MEMORY_SIZE = DEFAULT_MEMORY_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] mem_word,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] wa,
    input  logic [WORD_SIZE-1:0] wd,
    output logic [WORD_SIZE-1:0] data,
    output logic                 valid
);

    // One extra bit so that MEMORY_SIZE == 2^ADDR_SIZE is representable
    localparam logic [ADDR_SIZE:0] MEM_LIMIT = (ADDR_SIZE + 1)'(MEMORY_SIZE);

    logic in_range;
    logic bypass;

    assign in_range = ({1'b0, addr} < MEM_LIMIT);
    assign bypass   = we && (wa == addr);

    // Capture read data on an accepted request; valid follows the request, data holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (enable && re) begin
            valid <= 1'b1;
            if (!in_range) begin
                data <= '0;
            end else if (bypass) begin
                data <= wd;
            end else begin
                data <= mem_word;
            end
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_unit_2r1w.sv
// Two-read, one-write word memory with a post-reset hardware clear sequence.
module mem_unit_2r1w
    import mem_pkg::*;
#(
    parameter int WORD_SIZE   = DEFAULT_WORD_SIZE,
    parameter int ADDR_SIZE   = DEFAULT_ADDR_SIZE,
    parameter int MEMORY_SIZE = DEFAULT_MEMORY_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RE1,
    input  logic [ADDR_SIZE-1:0] A1,
    output logic [WORD_SIZE-1:0] D1,
    output logic                 V1,
    input  logic                 RE2,
    input  logic [ADDR_SIZE-1:0] A2,
    output logic [WORD_SIZE-1:0] D2,
    output logic                 V2,
    input  logic                 WE,
    input  logic [ADDR_SIZE-1:0] WA,
    input  logic [WORD_SIZE-1:0] WD,
    output logic                 ready
);

    localparam int                 CW         = clear_cnt_width(MEMORY_SIZE);
    localparam logic [CW-1:0]      CLEAR_LAST = CW'(MEMORY_SIZE - 1);
    localparam logic [ADDR_SIZE:0] MEM_LIMIT  = (ADDR_SIZE + 1)'(MEMORY_SIZE);

    mem_state_t          state;
    mem_state_t          next_state;
    logic [CW-1:0]       clear_cnt;
    logic                clear_en;
    logic                access_en;
    logic                write_en;
    logic                port_we;
    logic [WORD_SIZE-1:0] rd_word1;
    logic [WORD_SIZE-1:0] rd_word2;
    logic [WORD_SIZE-1:0] mem [MEMORY_SIZE];

    // State register and clear counter; reset restarts the clear from address 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            clear_cnt <= '0;
        end else begin
            state <= next_state;
            if (clear_en) begin
                clear_cnt <= clear_cnt + CW'(1);
            end
        end
    end

    // Leave CLEAR on the edge that zeroes the last word
    always_comb begin
        next_state = state;
        case (state)
            CLEAR:   if (clear_cnt == CLEAR_LAST) next_state = READY;
            READY:   next_state = READY;
            default: next_state = CLEAR;
        endcase
    end

    // Decode state into clear/access enables; ready comes straight from the state register
    always_comb begin
        clear_en  = 1'b0;
        access_en = 1'b0;
        case (state)
            CLEAR:   clear_en  = 1'b1;
            READY:   access_en = 1'b1;
            default: clear_en  = 1'b1;
        endcase
        ready = access_en;
    end

    assign port_we  = access_en && WE;
    assign write_en = port_we && ({1'b0, WA} < MEM_LIMIT);

    // Array update: zeroing during clear, otherwise in-range writes from the write port
    always_ff @(posedge clk) begin
        if (clear_en) begin
            mem[clear_cnt] <= '0;
        end else if (write_en) begin
            mem[WA] <= WD;
        end
    end

    assign rd_word1 = mem[A1];
    assign rd_word2 = mem[A2];

    mem_read_port #(
        .WORD_SIZE  (WORD_SIZE),
        .ADDR_SIZE  (ADDR_SIZE),
        .MEMORY_SIZE(MEMORY_SIZE)
    ) u_port1 (
        .clk     (clk),
        .rst     (rst),
        .enable  (access_en),
        .re      (RE1),
        .addr    (A1),
        .mem_word(rd_word1),
        .we      (port_we),
        .wa      (WA),
        .wd      (WD),
        .data    (D1),
        .valid   (V1)
    );

    mem_read_port #(
        .WORD_SIZE  (WORD_SIZE),
        .ADDR_SIZE  (ADDR_SIZE),
        .MEMORY_SIZE(MEMORY_SIZE)
    ) u_port2 (
        .clk     (clk),
        .rst     (rst),
        .enable  (access_en),
        .re      (RE2),
        .addr    (A2),
        .mem_word(rd_word2),
        .we      (port_we),
        .wa      (WA),
        .wd      (WD),
        .data    (D2),
        .valid   (V2)
    );

endmodule

// File: tb/tb_mem_unit_2r1w.sv
// Testbench for mem_unit_2r1w: a 512-word and a 300-word instance share one stimulus stream.
module tb_mem_unit_2r1w;

    typedef struct {
        logic [9:0] bd1;
        logic       bv1;
        logic [9:0] bd2;
        logic       bv2;
        logic [9:0] sd1;
        logic       sv1;
        logic [9:0] sd2;
        logic       sv2;
    } exp_t;

    typedef struct {
        logic       we;
        logic [8:0] wa;
        logic [9:0] wd;
        logic       re1;
        logic [8:0] a1;
        logic       re2;
        logic [8:0] a2;
        exp_t       exp;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       re1;
    logic [8:0] a1;
    logic       re2;
    logic [8:0] a2;
    logic       we;
    logic [8:0] wa;
    logic [9:0] wd;

    logic [9:0] b_d1;
    logic       b_v1;
    logic [9:0] b_d2;
    logic       b_v2;
    logic       b_ready;
    logic [9:0] s_d1;
    logic       s_v1;
    logic [9:0] s_d2;
    logic       s_v2;
    logic       s_ready;

    int   errors;
    int   checks;
    exp_t exp_q[$];
    vec_t vecs[17];

    mem_unit_2r1w u_big (
        .clk  (clk),
        .rst  (rst),
        .RE1  (re1),
        .A1   (a1),
        .D1   (b_d1),
        .V1   (b_v1),
        .RE2  (re2),
        .A2   (a2),
        .D2   (b_d2),
        .V2   (b_v2),
        .WE   (we),
        .WA   (wa),
        .WD   (wd),
        .ready(b_ready)
    );

    mem_unit_2r1w #(.MEMORY_SIZE(300)) u_small (
        .clk  (clk),
        .rst  (rst),
        .RE1  (re1),
        .A1   (a1),
        .D1   (s_d1),
        .V1   (s_v1),
        .RE2  (re2),
        .A2   (a2),
        .D2   (s_d2),
        .V2   (s_v2),
        .WE   (we),
        .WA   (wa),
        .WD   (wd),
        .ready(s_ready)
    );

    // Free-running clock, 10-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [8:0] waddr, input logic [9:0] wdata,
                                input logic r1, input logic [8:0] addr1,
                                input logic r2, input logic [8:0] addr2,
                                input logic [9:0] bd1, input logic bv1,
                                input logic [9:0] bd2, input logic bv2,
                                input logic [9:0] sd1, input logic sv1,
                                input logic [9:0] sd2, input logic sv2);
        vec_t v;
        v.we  = w;
        v.wa  = waddr;
        v.wd  = wdata;
        v.re1 = r1;
        v.a1  = addr1;
        v.re2 = r2;
        v.a2  = addr2;
        v.exp.bd1 = bd1;
        v.exp.bv1 = bv1;
        v.exp.bd2 = bd2;
        v.exp.bv2 = bv2;
        v.exp.sd1 = sd1;
        v.exp.sv1 = sv1;
        v.exp.sd2 = sd2;
        v.exp.sv2 = sv2;
        return v;
    endfunction

    task automatic setIdle();
        we  = 1'b0;
        wa  = '0;
        wd  = '0;
        re1 = 1'b0;
        a1  = '0;
        re2 = 1'b0;
        a2  = '0;
    endtask

    // Drive one cycle of stimulus on the falling edge and queue its expected outputs
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        we  = v.we;
        wa  = v.wa;
        wd  = v.wd;
        re1 = v.re1;
        a1  = v.a1;
        re2 = v.re2;
        a2  = v.a2;
        exp_q.push_back(v.exp);
    endtask

    // Sample just after the rising edge and compare against the oldest queued expectation
    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, " big D1"},   b_d1,         e.bd1);
            check({tag, " big V1"},   {9'd0, b_v1}, {9'd0, e.bv1});
            check({tag, " big D2"},   b_d2,         e.bd2);
            check({tag, " big V2"},   {9'd0, b_v2}, {9'd0, e.bv2});
            check({tag, " small D1"}, s_d1,         e.sd1);
            check({tag, " small V1"}, {9'd0, s_v1}, {9'd0, e.sv1});
            check({tag, " small D2"}, s_d2,         e.sd2);
            check({tag, " small V2"}, {9'd0, s_v2}, {9'd0, e.sv2});
        end
    endtask

    // Count clear edges after reset release and check when each instance becomes ready
    task automatic runClear(input string tag);
        for (int edge_n = 1; edge_n <= 512; edge_n++) begin
            @(posedge clk);
            #1;
            if (edge_n == 5) begin
                check({tag, " big V1 in clear"},   {9'd0, b_v1}, 10'd0);
                check({tag, " small V1 in clear"}, {9'd0, s_v1}, 10'd0);
                setIdle();
            end
            if (edge_n == 299) check({tag, " small ready@299"}, {9'd0, s_ready}, 10'd0);
            if (edge_n == 300) check({tag, " small ready@300"}, {9'd0, s_ready}, 10'd1);
            if (edge_n == 511) check({tag, " big ready@511"},   {9'd0, b_ready}, 10'd0);
            if (edge_n == 512) check({tag, " big ready@512"},   {9'd0, b_ready}, 10'd1);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;

        //           we wa      wd       re1 a1     re2 a2     bD1     bV bD2     bV sD1     sV sD2     sV
        vecs[0]  = mk(0, 9'd0,   10'h000, 1, 9'd0,   1, 9'd255, 10'h000, 1, 10'h000, 1, 10'h000, 1, 10'h000, 1);
        vecs[1]  = mk(0, 9'd0,   10'h000, 1, 9'd511, 1, 9'd3,   10'h000, 1, 10'h000, 1, 10'h000, 1, 10'h000, 1);
        vecs[2]  = mk(1, 9'd5,   10'h2AA, 0, 9'd0,   0, 9'd0,   10'h000, 0, 10'h000, 0, 10'h000, 0, 10'h000, 0);
        vecs[3]  = mk(1, 9'd6,   10'h0F0, 0, 9'd0,   0, 9'd0,   10'h000, 0, 10'h000, 0, 10'h000, 0, 10'h000, 0);
        vecs[4]  = mk(0, 9'd0,   10'h000, 1, 9'd5,   1, 9'd6,   10'h2AA, 1, 10'h0F0, 1, 10'h2AA, 1, 10'h0F0, 1);
        vecs[5]  = mk(0, 9'd0,   10'h000, 0, 9'd0,   0, 9'd0,   10'h2AA, 0, 10'h0F0, 0, 10'h2AA, 0, 10'h0F0, 0);
        vecs[6]  = mk(1, 9'd9,   10'h011, 0, 9'd0,   0, 9'd0,   10'h2AA, 0, 10'h0F0, 0, 10'h2AA, 0, 10'h0F0, 0);
        vecs[7]  = mk(1, 9'd9,   10'h3FF, 1, 9'd9,   1, 9'd9,   10'h3FF, 1, 10'h3FF, 1, 10'h3FF, 1, 10'h3FF, 1);
        vecs[8]  = mk(0, 9'd0,   10'h000, 1, 9'd9,   1, 9'd5,   10'h3FF, 1, 10'h2AA, 1, 10'h3FF, 1, 10'h2AA, 1);
        vecs[9]  = mk(1, 9'd400, 10'h123, 0, 9'd0,   0, 9'd0,   10'h3FF, 0, 10'h2AA, 0, 10'h3FF, 0, 10'h2AA, 0);
        vecs[10] = mk(0, 9'd0,   10'h000, 1, 9'd400, 1, 9'd299, 10'h123, 1, 10'h000, 1, 10'h000, 1, 10'h000, 1);
        vecs[11] = mk(1, 9'd400, 10'h0AA, 1, 9'd400, 0, 9'd0,   10'h0AA, 1, 10'h000, 0, 10'h000, 1, 10'h000, 0);
        vecs[12] = mk(1, 9'd299, 10'h155, 1, 9'd299, 1, 9'd299, 10'h155, 1, 10'h155, 1, 10'h155, 1, 10'h155, 1);
        vecs[13] = mk(1, 9'd511, 10'h3C3, 0, 9'd0,   0, 9'd0,   10'h155, 0, 10'h155, 0, 10'h155, 0, 10'h155, 0);
        vecs[14] = mk(0, 9'd0,   10'h000, 1, 9'd511, 1, 9'd7,   10'h3C3, 1, 10'h000, 1, 10'h000, 1, 10'h000, 1);
        vecs[15] = mk(1, 9'd7,   10'h1FF, 0, 9'd0,   0, 9'd0,   10'h3C3, 0, 10'h000, 0, 10'h000, 0, 10'h000, 0);
        vecs[16] = mk(0, 9'd0,   10'h000, 1, 9'd7,   1, 9'd299, 10'h1FF, 1, 10'h155, 1, 10'h1FF, 1, 10'h155, 1);

        $display("[TB] starting mem_unit_2r1w bench");
        rst = 1'b1;
        setIdle();
        repeat (2) @(posedge clk);
        #1;
        check("reset big ready",   {9'd0, b_ready}, 10'd0);
        check("reset big V1",      {9'd0, b_v1},    10'd0);
        check("reset big D1",      b_d1,            10'h000);
        check("reset small ready", {9'd0, s_ready}, 10'd0);

        // Release reset with a write and reads pending; the clear must ignore them
        @(negedge clk);
        rst = 1'b0;
        we  = 1'b1;
        wa  = 9'd3;
        wd  = 10'h155;
        re1 = 1'b1;
        a1  = 9'd3;
        re2 = 1'b1;
        a2  = 9'd3;
        runClear("clear");

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // One-cycle reset pulse while ready: outputs drop immediately, clear restarts
        @(negedge clk);
        setIdle();
        rst = 1'b1;
        #1;
        check("midrst big ready",   {9'd0, b_ready}, 10'd0);
        check("midrst big V1",      {9'd0, b_v1},    10'd0);
        check("midrst big D1",      b_d1,            10'h000);
        check("midrst big D2",      b_d2,            10'h000);
        check("midrst small ready", {9'd0, s_ready}, 10'd0);
        check("midrst small D1",    s_d1,            10'h000);
        @(negedge clk);
        rst = 1'b0;
        runClear("reclear");

        applyStimulus(mk(0, 9'd0, 10'h000, 1, 9'd7, 1, 9'd299,
                         10'h000, 1, 10'h000, 1, 10'h000, 1, 10'h000, 1));
        checkOutput("after reclear");

        @(negedge clk);
        setIdle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_unit_2r1w.md
# mem_unit_2r1w

Parametrised two-read, one-write word memory; the next generation of the data-memory unit. It adds a synchronous write port, registered reads with valid flags, write-first bypass and a hardware clear sequence that zeroes every word after reset. It sits between the datapath's operand-fetch stage and the writeback stage; both read ports serve operand fetch in the same cycle.

## Interface
- WORD_SIZE, 10: data word width in bits.
- ADDR_SIZE, 9: address width in bits.
- MEMORY_SIZE, 512: number of words; must satisfy 1 ≤ MEMORY_SIZE ≤ 2^ADDR_SIZE.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- RE1  in  1  read request, port 1.
- A1  in  ADDR_SIZE  read address, port 1.
- D1  out  WORD_SIZE  read data, port 1 (registered).
- V1  out  1  D1 valid.
- RE2, A2, D2, V2: port 2, identical to port 1.
- WE  in  1  write enable.
- WA  in  ADDR_SIZE  write address.
- WD  in  WORD_SIZE  write data.
- ready  out  1  clear sequence complete; accesses are accepted.

## Operation
- FSM states: CLEAR, READY. rst forces CLEAR and clear counter = 0, from either state, including mid-clear or mid-access.
- CLEAR: each edge writes 0 to Memory[counter], then counter += 1. On the edge that writes MEMORY_SIZE-1, go to READY. WE, RE1 and RE2 are ignored, and V1 = V2 = 0.
- READY, write: if WE=1 and WA < MEMORY_SIZE, Memory[WA] ← WD at the edge. If WA ≥ MEMORY_SIZE, the write is dropped silently.
- READY, read port n:
  - If REn=1, then at the edge Dn ← Memory[An] and Vn ← 1.
  - If REn=0, then Vn ← 0 and Dn holds its previous value.
- Write-first bypass: if WE=1, REn=1 and WA == An < MEMORY_SIZE in the same cycle, Dn ← WD. Both ports may bypass at once.
- If An ≥ MEMORY_SIZE with REn=1: Dn ← 0 and Vn ← 1.
- Both ports may read the same address in the same cycle; each returns the same data.
- Reset values: D1 = D2 = 0, V1 = V2 = 0, ready = 0. Array contents are undefined until the clear sequence completes.

## Timing
- Read latency is 1 cycle: a request at edge k produces Dn/Vn valid after edge k, for one cycle per request. Back-to-back reads are supported every cycle.
- A write at edge k is visible to a read request sampled at edge k (via bypass) and to any later request.
- After rst deasserts, the clear sequence takes exactly MEMORY_SIZE edges. ready rises after edge MEMORY_SIZE.
- The first access is accepted at the edge following ready = 1.
- Asserting rst mid-clear restarts the sequence from address 0.
- ready is asserted exactly when state = READY (registered, no combinational path from inputs).
- No combinational path from any input to any output.

## Structure
- Package mem_pkg:
  - state enum {CLEAR, READY};
  - default width constants;
  - a function deriving the clear-counter width, clog2(MEMORY_SIZE), minimum 1.
- Sub-module mem_read_port, instantiated twice. It holds:
  - registered read data with bypass compare;
  - out-of-range zeroing;
  - valid flag.
- Array, write logic and clear FSM stay in the top module.

## Test plan
- Reset/clear, MEMORY_SIZE=512:
  - ready = 0 through edge 511 and 1 after edge 512.
  - Reading addresses 0, 255 and 511 returns D = 0 with V = 1.
  - WE=1 with WA=3, WD=0x155 issued during CLEAR is ignored: address 3 reads 0.
- Write/read: write 0x2AA@5 and 0x0F0@6, then RE1 A1=5 and RE2 A2=6 in the same cycle → next cycle D1 = 0x2AA, D2 = 0x0F0, V1 = V2 = 1. With RE low the following cycle, V = 0 and D holds its value.
- Bypass: Memory[9] = 0x011; then WE WA=9 WD=0x3FF with RE1 A1=9 and RE2 A2=9 in the same cycle → D1 = D2 = 0x3FF.
- Out of range, MEMORY_SIZE=300:
  - Write 0x123 to WA=400: dropped.
  - Read A1=400: D1 = 0, V1 = 1.
  - Read A1=299: returns 0 after clear.
- Reset mid-operation: write 0x1FF@7 and let ready rise, then pulse rst for 1 cycle. ready = 0, V = 0 and D = 0 immediately; after 512 edges, ready = 1 and address 7 reads 0.
